// File: rtl/avs_i2s_pkg.sv
// Shared definitions for the avs_i2s_tx Avalon-MM I2S transmitter:
// register offsets, CONTROL/STATUS bit positions and serialiser states.
package avs_i2s_pkg;

    localparam logic [2:0] ADDR_LEFT    = 3'd0;
    localparam logic [2:0] ADDR_RIGHT   = 3'd1;
    localparam logic [2:0] ADDR_CONTROL = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_CLKDIV  = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MONO     = 1;
    localparam int CTRL_CLR      = 2;
    localparam int CTRL_IE_UNDER = 3;
    localparam int CTRL_IE_LOW   = 4;
    localparam int CTRL_THR_LSB  = 8;
    localparam int CTRL_THR_MSB  = 15;

    localparam int STAT_UNDER   = 0;
    localparam int STAT_OVER    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_FULL    = 3;
    localparam int STAT_LVL_LSB = 8;
    localparam int STAT_LVL_MSB = 23;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/avs_sync_fifo.sv
// Single-clock FIFO with show-ahead read data, synchronous flush and level.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module avs_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [AW:0]   count_q, count_d;
    logic          doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (doPush && !clr_i) mem_q[wrPtr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign level_o = count_q;

endmodule

// File: rtl/avs_i2s_tx.sv
// Avalon-MM slave Philips-I2S stereo transmitter: CPU-fed frame FIFO,
// programmable bit clock divider, mono mode, sticky error flags and irq.
module avs_i2s_tx
    import avs_i2s_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    output logic        avs_s0_waitrequest,
    output logic [31:0] avs_s0_readdata,
    input  logic [31:0] avs_s0_writedata,
    output logic        avs_s0_irq,
    output logic        avs_s0_export_i2s_sck,
    output logic        avs_s0_export_i2s_ws,
    output logic        avs_s0_export_i2s_sd
);
    localparam int FW  = 2 * DW;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(FW);

    logic [DW-1:0]    left_q;
    logic             en_q, mono_q, ieUnder_q, ieLow_q;
    logic [7:0]       lowThr_q;
    logic [DIV_W-1:0] clkDiv_q;
    logic             underrun_q, overflow_q;

    state_e           state_q;
    logic [DIV_W-1:0] divCnt_q, divLat_q;
    logic             sck_q, ws_q, sd_q, ws_d;
    logic [BCW-1:0]   bitCnt_q, bitCnt_d;
    logic [FW-1:0]    shift_q, frame_d;

    logic             wrLeft, wrRight, wrCtrl, wrStat, wrDiv;
    logic [DW-1:0]    wSample;
    logic             push, pop, clr;
    logic [FW-1:0]    pushData, fifoRdata;
    logic             fifoFull, fifoEmpty;
    logic [AW:0]      fifoLevel;
    logic             tick, fallEvt, frameStart, underrunSet, overflowSet;
    logic             unusedWriteBits;

    assign wrLeft  = avs_s0_write && (avs_s0_address == ADDR_LEFT);
    assign wrRight = avs_s0_write && (avs_s0_address == ADDR_RIGHT);
    assign wrCtrl  = avs_s0_write && (avs_s0_address == ADDR_CONTROL);
    assign wrStat  = avs_s0_write && (avs_s0_address == ADDR_STATUS);
    assign wrDiv   = avs_s0_write && (avs_s0_address == ADDR_CLKDIV);
    assign wSample = avs_s0_writedata[DW-1:0];
    assign unusedWriteBits = ^avs_s0_writedata;

    // In mono mode the LEFT write itself queues the frame; RIGHT is ignored.
    assign push     = mono_q ? wrLeft : wrRight;
    assign pushData = mono_q ? {wSample, wSample} : {left_q, wSample};
    assign clr      = wrCtrl && avs_s0_writedata[CTRL_CLR];

    assign tick        = (state_q == RUN) && en_q && (divCnt_q == divLat_q);
    assign fallEvt     = tick && sck_q;
    assign frameStart  = fallEvt && (bitCnt_q == '0);
    assign pop         = frameStart && !fifoEmpty;
    assign underrunSet = frameStart && fifoEmpty;
    assign overflowSet = push && fifoFull && !pop && !clr;

    avs_sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (pushData),
        .pop_i   (pop),
        .clr_i   (clr),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_q     <= '0;
            en_q       <= 1'b0;
            mono_q     <= 1'b0;
            ieUnder_q  <= 1'b0;
            ieLow_q    <= 1'b0;
            lowThr_q   <= '0;
            clkDiv_q   <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wrLeft) left_q <= wSample;
            if (wrCtrl) begin
                en_q      <= avs_s0_writedata[CTRL_EN];
                mono_q    <= avs_s0_writedata[CTRL_MONO];
                ieUnder_q <= avs_s0_writedata[CTRL_IE_UNDER];
                ieLow_q   <= avs_s0_writedata[CTRL_IE_LOW];
                lowThr_q  <= avs_s0_writedata[CTRL_THR_MSB:CTRL_THR_LSB];
            end
            if (wrDiv) clkDiv_q <= avs_s0_writedata[DIV_W-1:0];
            // A new error event wins over a simultaneous write-1-to-clear.
            underrun_q <= underrunSet | (underrun_q & ~(wrStat & avs_s0_writedata[STAT_UNDER]));
            overflow_q <= overflowSet | (overflow_q & ~(wrStat & avs_s0_writedata[STAT_OVER]));
        end
    end

    always_comb begin
        frame_d = shift_q;
        if (bitCnt_q == '0) frame_d = fifoEmpty ? '0 : fifoRdata;
        ws_d     = (bitCnt_q >= BCW'(DW-1)) && (bitCnt_q <= BCW'(FW-2));
        bitCnt_d = (bitCnt_q == BCW'(FW-1)) ? '0 : bitCnt_q + 1'b1;
    end

    // Divider period is latched at each reload so CLK_DIV edits never cut a half-period short.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            divCnt_q <= '0;
            divLat_q <= '0;
            sck_q    <= 1'b0;
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            bitCnt_q <= '0;
            shift_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_q) begin
                        state_q  <= RUN;
                        divCnt_q <= '0;
                        divLat_q <= clkDiv_q;
                        sck_q    <= 1'b0;
                        bitCnt_q <= '0;
                    end
                end
                RUN: begin
                    if (!en_q) begin
                        state_q  <= IDLE;
                        divCnt_q <= '0;
                        sck_q    <= 1'b0;
                        ws_q     <= 1'b0;
                        sd_q     <= 1'b0;
                        bitCnt_q <= '0;
                    end else if (tick) begin
                        divCnt_q <= '0;
                        divLat_q <= clkDiv_q;
                        sck_q    <= ~sck_q;
                        if (sck_q) begin
                            sd_q     <= frame_d[FW-1];
                            shift_q  <= frame_d << 1;
                            ws_q     <= ws_d;
                            bitCnt_q <= bitCnt_d;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        avs_s0_readdata = '0;
        if (avs_s0_read) begin
            case (avs_s0_address)
                ADDR_LEFT: avs_s0_readdata[DW-1:0] = left_q;
                ADDR_CONTROL: begin
                    avs_s0_readdata[CTRL_EN]                   = en_q;
                    avs_s0_readdata[CTRL_MONO]                 = mono_q;
                    avs_s0_readdata[CTRL_IE_UNDER]             = ieUnder_q;
                    avs_s0_readdata[CTRL_IE_LOW]               = ieLow_q;
                    avs_s0_readdata[CTRL_THR_MSB:CTRL_THR_LSB] = lowThr_q;
                end
                ADDR_STATUS: begin
                    avs_s0_readdata[STAT_UNDER]                = underrun_q;
                    avs_s0_readdata[STAT_OVER]                 = overflow_q;
                    avs_s0_readdata[STAT_EMPTY]                = fifoEmpty;
                    avs_s0_readdata[STAT_FULL]                 = fifoFull;
                    avs_s0_readdata[STAT_LVL_MSB:STAT_LVL_LSB] = 16'(fifoLevel);
                end
                ADDR_CLKDIV: avs_s0_readdata[DIV_W-1:0] = clkDiv_q;
                default: avs_s0_readdata = '0;
            endcase
        end
    end

    assign avs_s0_waitrequest    = 1'b0;
    assign avs_s0_irq            = (ieUnder_q & underrun_q)
                                 | (ieLow_q & en_q & (16'(fifoLevel) <= 16'(lowThr_q)));
    assign avs_s0_export_i2s_sck = sck_q;
    assign avs_s0_export_i2s_ws  = ws_q;
    assign avs_s0_export_i2s_sd  = sd_q;

endmodule
